// File: rtl/display_timings.sv
// Parametrised progressive-scan video timing generator (640x480@60 defaults).
// Every output is a flop describing the coordinate currently driven, so flags never skew from sx/sy.
module display_timings #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int FRAMEW = 16
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              en,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              hblank,
  output logic              vblank,
  output logic              line,
  output logic              frame,
  output logic [FRAMEW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  // Reject degenerate geometry and coordinate widths that cannot hold the totals.
  generate
    if (CORDW < 1 || CORDW > 30 || FRAMEW < 1 ||
        H_RES < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_RES < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (H_TOTAL - 1) >= (1 << CORDW) || (V_TOTAL - 1) >= (1 << CORDW)) begin : g_bad_params
      $error("display_timings: invalid timing parameters");
    end
  endgenerate

  function automatic logic in_window(input logic [CORDW-1:0] v,
                                     input logic [CORDW-1:0] lo,
                                     input logic [CORDW-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  logic [CORDW-1:0] nx_p0;
  logic [CORDW-1:0] ny_p0;
  logic             wrap_p0;

  // Stage p0: next raster position; flags below are derived from it so they land with sx/sy.
  always_comb begin
    nx_p0   = sx + CORDW'(1);
    ny_p0   = sy;
    wrap_p0 = 1'b0;
    if (sx == H_LAST) begin
      nx_p0 = '0;
      if (sy == V_LAST) begin
        ny_p0   = '0;
        wrap_p0 = 1'b1;
      end else begin
        ny_p0 = sy + CORDW'(1);
      end
    end
  end

  // Stage p1: registered outputs. Strobes self-clear every clock so they never stretch while en=0.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx        <= H_LAST;
      sy        <= V_LAST;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      de        <= 1'b0;
      hblank    <= 1'b1;
      vblank    <= 1'b1;
      line      <= 1'b0;
      frame     <= 1'b0;
      frame_cnt <= '1;
    end else begin
      line  <= 1'b0;
      frame <= 1'b0;
      if (en) begin
        sx     <= nx_p0;
        sy     <= ny_p0;
        hsync  <= sync_level(in_window(nx_p0, HS_START, HS_END), H_POL);
        vsync  <= sync_level(in_window(ny_p0, VS_START, VS_END), V_POL);
        de     <= (nx_p0 < H_ACT) && (ny_p0 < V_ACT);
        hblank <= (nx_p0 >= H_ACT);
        vblank <= (ny_p0 >= V_ACT);
        line   <= (nx_p0 == '0);
        frame  <= wrap_p0;
        if (wrap_p0) frame_cnt <= frame_cnt + FRAMEW'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: three geometries driven in lockstep, checked cycle by cycle
// against a linear-pixel-index reference model through an expected-value queue.
module tb_display_timings;

  localparam int NI = 3;
  // Instance 0: 640x480 defaults, 1: 1280x720 positive sync, 2: tiny raster with 3-bit frame counter.
  int hres [NI] = '{640, 1280, 8};
  int hfp  [NI] = '{16, 110, 2};
  int hsw  [NI] = '{96, 40, 3};
  int hbp  [NI] = '{48, 220, 2};
  int vres [NI] = '{480, 720, 4};
  int vfp  [NI] = '{10, 5, 1};
  int vsw  [NI] = '{2, 5, 2};
  int vbp  [NI] = '{33, 20, 1};
  bit hpol [NI] = '{1'b0, 1'b1, 1'b1};
  bit vpol [NI] = '{1'b0, 1'b1, 1'b1};
  int fw   [NI] = '{16, 16, 3};

  typedef struct packed {
    logic [15:0] sx;
    logic [15:0] sy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        hb;
    logic        vb;
    logic        ln;
    logic        fr;
    logic [15:0] fc;
  } obs_t;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;

  logic [9:0]  sx_a, sy_a;
  logic        hsync_a, vsync_a, de_a, hblank_a, vblank_a, line_a, frame_a;
  logic [15:0] fc_a;
  logic [10:0] sx_b, sy_b;
  logic        hsync_b, vsync_b, de_b, hblank_b, vblank_b, line_b, frame_b;
  logic [15:0] fc_b;
  logic [3:0]  sx_c, sy_c;
  logic        hsync_c, vsync_c, de_c, hblank_c, vblank_c, line_c, frame_c;
  logic [2:0]  fc_c;

  always #5 clk_pix = ~clk_pix;

  display_timings dut_a (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .sx(sx_a), .sy(sy_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .hblank(hblank_a), .vblank(vblank_a), .line(line_a), .frame(frame_a), .frame_cnt(fc_a)
  );

  display_timings #(
    .CORDW(11), .H_RES(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_RES(720), .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(16)
  ) dut_b (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .sx(sx_b), .sy(sy_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .hblank(hblank_b), .vblank(vblank_b), .line(line_b), .frame(frame_b), .frame_cnt(fc_b)
  );

  display_timings #(
    .CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(3)
  ) dut_c (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .sx(sx_c), .sy(sy_c), .hsync(hsync_c), .vsync(vsync_c), .de(de_c),
    .hblank(hblank_c), .vblank(vblank_c), .line(line_c), .frame(frame_c), .frame_cnt(fc_c)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: position as a single pixel index into the frame.
  int mp  [NI];
  int mfc [NI];
  bit mln [NI];
  bit mfr [NI];

  obs_t exp_q[$];

  function automatic int htot(int k);
    return hres[k] + hfp[k] + hsw[k] + hbp[k];
  endfunction

  function automatic int vtot(int k);
    return vres[k] + vfp[k] + vsw[k] + vbp[k];
  endfunction

  function automatic obs_t model_out(int k);
    obs_t o;
    int x, y;
    bit hs_act, vs_act;
    x = mp[k] % htot(k);
    y = mp[k] / htot(k);
    hs_act = (x >= hres[k] + hfp[k]) && (x < hres[k] + hfp[k] + hsw[k]);
    vs_act = (y >= vres[k] + vfp[k]) && (y < vres[k] + vfp[k] + vsw[k]);
    o.sx = 16'(x);
    o.sy = 16'(y);
    o.hs = hs_act ? hpol[k] : !hpol[k];
    o.vs = vs_act ? vpol[k] : !vpol[k];
    o.de = (x < hres[k]) && (y < vres[k]);
    o.hb = (x >= hres[k]);
    o.vb = (y >= vres[k]);
    o.ln = mln[k];
    o.fr = mfr[k];
    o.fc = 16'(mfc[k]);
    return o;
  endfunction

  function automatic obs_t get_obs(int k);
    obs_t o;
    o = '0;
    case (k)
      0: begin
        o.sx = 16'(sx_a); o.sy = 16'(sy_a); o.hs = hsync_a; o.vs = vsync_a; o.de = de_a;
        o.hb = hblank_a; o.vb = vblank_a; o.ln = line_a; o.fr = frame_a; o.fc = fc_a;
      end
      1: begin
        o.sx = 16'(sx_b); o.sy = 16'(sy_b); o.hs = hsync_b; o.vs = vsync_b; o.de = de_b;
        o.hb = hblank_b; o.vb = vblank_b; o.ln = line_b; o.fr = frame_b; o.fc = fc_b;
      end
      default: begin
        o.sx = 16'(sx_c); o.sy = 16'(sy_c); o.hs = hsync_c; o.vs = vsync_c; o.de = de_c;
        o.hb = hblank_c; o.vb = vblank_c; o.ln = line_c; o.fr = frame_c; o.fc = 16'(fc_c);
      end
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mp[k]  = htot(k) * vtot(k) - 1;
      mfc[k] = (1 << fw[k]) - 1;
      mln[k] = 1'b0;
      mfr[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit e);
    for (int k = 0; k < NI; k++) begin
      if (e) begin
        mp[k]  = (mp[k] + 1) % (htot(k) * vtot(k));
        mln[k] = (mp[k] % htot(k)) == 0;
        mfr[k] = (mp[k] == 0);
        if (mfr[k]) mfc[k] = (mfc[k] + 1) & ((1 << fw[k]) - 1);
      end else begin
        mln[k] = 1'b0;
        mfr[k] = 1'b0;
      end
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < NI; k++) exp_q.push_back(model_out(k));
  endtask

  task automatic check_outputs(input string tag);
    obs_t e, g;
    for (int k = 0; k < NI; k++) begin
      e = exp_q.pop_front();
      g = get_obs(k);
      n_checks++;
      assert (g === e) else begin
        n_err++;
        $error("FAIL %s[%0d] observed sx=%0d sy=%0d hs=%b vs=%b de=%b hb=%b vb=%b ln=%b fr=%b fc=%0d expected sx=%0d sy=%0d hs=%b vs=%b de=%b hb=%b vb=%b ln=%b fr=%b fc=%0d",
               tag, k, g.sx, g.sy, g.hs, g.vs, g.de, g.hb, g.vb, g.ln, g.fr, g.fc,
               e.sx, e.sy, e.hs, e.vs, e.de, e.hb, e.vb, e.ln, e.fr, e.fc);
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Drive en for the next edge, queue what the model predicts, compare just after the edge.
  task automatic step(input bit e, input string tag);
    en = e;
    model_edge(e);
    push_expected();
    @(posedge clk_pix);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int hs_low, de_cnt, hb_cnt, ln_cnt, hs_b, fr_c, vs_c_low;
    bit e;

    // Reset state
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    model_reset();
    push_expected();
    check_outputs("reset");
    chk("reset_fc_a", int'(fc_a), 16'hFFFF);

    // Release away from the edge; first enabled edge must produce (0,0) with both strobes.
    rst_n = 1'b1;
    step(1'b1, "first");
    chk("first_sx", int'(sx_a), 0);
    chk("first_frame", int'(frame_a), 1);
    chk("first_line", int'(line_a), 1);
    chk("first_fc", int'(fc_a), 0);
    chk("first_de", int'(de_a), 1);

    // Rest of line 0 of 640x480, then line 1 starts.
    hs_low = 0; de_cnt = 1; hb_cnt = 0; ln_cnt = 0; hs_b = int'(hsync_b); fr_c = 1; vs_c_low = 0;
    for (int i = 1; i < 800; i++) begin
      step(1'b1, "line_a");
      if (!hsync_a) hs_low++;
      if (de_a) de_cnt++;
      if (hblank_a) hb_cnt++;
      if (line_a) ln_cnt++;
      if (hsync_b) hs_b++;
      if (frame_c) fr_c++;
    end
    chk("hsync_low_cycles", hs_low, 96);
    chk("de_cycles", de_cnt, 640);
    chk("hblank_cycles", hb_cnt, 160);
    chk("line_pulses_in_line", ln_cnt, 0);
    step(1'b1, "line_wrap");
    chk("line1_sy", int'(sy_a), 1);
    chk("line1_strobe", int'(line_a), 1);

    // Finish one 720p line: hsync high for exactly 40 pixels.
    for (int i = 801; i < 1650; i++) begin
      step(1'b1, "line_b");
      if (hsync_b) hs_b++;
      if (frame_c) fr_c++;
    end
    chk("hsync_b_high_cycles", hs_b, 40);
    chk("frames_c_in_1650", fr_c, (1650 + 119) / 120);

    // en every 3rd cycle: third-rate scan, strobes stay one cycle wide.
    for (int i = 0; i < 600; i++) step((i % 3) == 2, "en_div3");

    // en toggling every cycle.
    for (int i = 0; i < 400; i++) step(i[0], "en_toggle");

    // Random enable pattern.
    for (int i = 0; i < 500; i++) begin
      e = $urandom_range(0, 1) != 0;
      step(e, "en_rand");
      if (!vsync_c) vs_c_low++;
    end

    // Asynchronous reset in the middle of a clock period: outputs must change with no edge.
    for (int i = 0; i < 37; i++) step(1'b1, "pre_rst");
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_expected();
    check_outputs("async_rst");
    chk("async_rst_line", int'(line_a), 0);
    chk("async_rst_frame", int'(frame_c), 0);
    @(posedge clk_pix);
    #1;
    push_expected();
    check_outputs("held_rst");
    rst_n = 1'b1;
    step(1'b1, "post_rst");
    chk("post_rst_fc", int'(fc_a), 0);
    chk("post_rst_frame", int'(frame_b), 1);
    for (int i = 0; i < 300; i++) step(1'b1, "post_rst_run");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
